// File: rtl/mm_array_ctrl.sv
// rtl/mm_array_ctrl.sv - sequencer for the NxN fixed-point matrix-multiply PE array
module mm_array_ctrl #(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int DRAIN_CYC    = 6,
    localparam int AW = (N > 1) ? $clog2(N) : 1,
    localparam int RW = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [AW-1:0]                    op_addr,
    output logic                             op_en,
    input  logic [N*DATA_WIDTH-1:0]          a_rdata,
    input  logic [N*DATA_WIDTH-1:0]          b_rdata,
    output logic [N*DATA_WIDTH-1:0]          row_data,
    output logic [N*DATA_WIDTH-1:0]          col_weight,
    output logic                             pe_clear,
    input  logic [N*N*OUTPUT_WIDTH-1:0]      arr_result,
    output logic                             wr_en,
    input  logic                             wr_ready,
    output logic [RW-1:0]                    wr_addr,
    output logic [OUTPUT_WIDTH-1:0]          wr_data
);

    // One counter serves FETCH, DRAIN and WRITEBACK, so size it for the longest phase.
    localparam int CNT_MAX = (N * N > DRAIN_CYC) ? N * N : DRAIN_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            feed_vld_q, feed_vld_d;
    logic [N*DATA_WIDTH-1:0]         row_q, row_d;
    logic [N*DATA_WIDTH-1:0]         col_q, col_d;
    logic                            pe_clear_q, pe_clear_d;
    logic [N*N*OUTPUT_WIDTH-1:0]     snap_q, snap_d;
    logic [RW-1:0]                   wb_idx;

    assign wb_idx     = cnt_q[RW-1:0];
    assign row_data   = row_q;
    assign col_weight = col_q;
    assign pe_clear   = pe_clear_q;

    // Next-state, counter, snapshot capture and per-state outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        op_en   = 1'b0;
        op_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                op_en   = 1'b1;
                op_addr = cnt_q[AW-1:0];
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // The last drain cycle is the first one where every PE output is final.
                if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                    snap_d  = arr_result;
                    cnt_d   = '0;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                wr_en   = 1'b1;
                wr_addr = wb_idx;
                for (int i = 0; i < N * N; i++) begin
                    if (wb_idx == RW'(i)) begin
                        wr_data = snap_q[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                    end
                end
                if (wr_ready) begin
                    if (cnt_q == CW'(N * N - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Feed path: memory data lands one cycle after op_en; zero otherwise so the array holds.
    always_comb begin
        feed_vld_d = op_en;
        row_d      = feed_vld_q ? a_rdata : '0;
        col_d      = feed_vld_q ? b_rdata : '0;
        pe_clear_d = (state_d == S_CLEAR);
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            feed_vld_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            pe_clear_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            feed_vld_q <= feed_vld_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pe_clear_q <= pe_clear_d;
            snap_q     <= snap_d;
        end
    end

endmodule

// File: tb/tb_mm_array_ctrl.sv
// tb/tb_mm_array_ctrl.sv - randomized self-checking bench for mm_array_ctrl
module tb_mm_array_ctrl;
    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int OW  = 12;
    localparam int DC  = 6;
    localparam int WB0 = N + 2 + DC;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 busy, done, op_en, pe_clear, wr_en;
    logic [1:0]           op_addr;
    logic [N*DW-1:0]      a_rdata = '0, b_rdata = '0;
    logic [N*DW-1:0]      row_data, col_weight;
    logic [N*N*OW-1:0]    arr_result = '0;
    logic                 wr_ready = 1'b1;
    logic [3:0]           wr_addr;
    logic [OW-1:0]        wr_data;

    mm_array_ctrl #(.N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .DRAIN_CYC(DC)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .op_addr(op_addr), .op_en(op_en), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .row_data(row_data), .col_weight(col_weight), .pe_clear(pe_clear),
        .arr_result(arr_result), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic signed [DW-1:0] ma [N][N];
    logic signed [DW-1:0] mb [N][N];
    logic [OW-1:0]        exp_c [N*N];
    logic [OW-1:0]        got   [N*N];

    bit m_active = 1'b0;
    int m_rel = 0, m_xfers = 0;
    int start_cyc = 0, done_cyc = 0, pc_cnt = 0, pc_cyc = 0, busy_cnt = 0;

    logic [OW-1:0]        acc [N*N] = '{default: '0};
    logic [N*N*OW-1:0]    pipe [5] = '{default: '0};
    bit                   pend = 1'b0;
    int                   pend_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] qmul(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return p[DW+5:6];
    endfunction

    function automatic void compute_expected();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [OW-1:0] s;
                s = '0;
                for (int k = 0; k < N; k++) s = s + qmul(ma[i][k], mb[k][j]);
                exp_c[i*N+j] = s;
            end
    endfunction

    // Model + compare, then memory stub and PE-array stub, all mid-cycle.
    always @(negedge clk) begin
        logic e_pc, e_op, e_wb, e_done;
        logic [N*DW-1:0] e_row, e_col;
        logic [N*N*OW-1:0] tmp;
        logic [63:0] rnd;
        if (rst) begin
            chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
            chk("rst_op_en", op_en, 0);     chk("rst_pe_clear", pe_clear, 0);
            chk("rst_wr_en", wr_en, 0);     chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0); chk("rst_row", row_data, 0);
            chk("rst_col", col_weight, 0);
            m_active = 1'b0;
        end else begin
            e_pc   = m_active && m_rel == 1;
            e_op   = m_active && m_rel >= 2 && m_rel <= N + 1;
            e_wb   = m_active && m_rel >= WB0 && m_xfers < N * N;
            e_done = m_active && m_rel >= WB0 && m_xfers == N * N;
            e_row  = '0;
            e_col  = '0;
            if (m_active && m_rel >= 4 && m_rel <= N + 3)
                for (int l = 0; l < N; l++) begin
                    e_row[l*DW +: DW] = ma[l][m_rel-4];
                    e_col[l*DW +: DW] = mb[m_rel-4][l];
                end
            chk("busy", busy, m_active);
            chk("done", done, e_done);
            chk("pe_clear", pe_clear, e_pc);
            chk("op_en", op_en, e_op);
            chk("wr_en", wr_en, e_wb);
            chk("row_data", row_data, e_row);
            chk("col_weight", col_weight, e_col);
            if (e_op) chk("op_addr", op_addr, m_rel - 2);
            if (pe_clear) begin pc_cnt++; pc_cyc = cyc; end
            if (busy) busy_cnt++;
            if (e_wb) begin
                chk("wr_addr", wr_addr, m_xfers);
                chk("wr_data", wr_data, exp_c[m_xfers]);
                if (wr_ready) begin
                    got[m_xfers] = wr_data;
                    m_xfers++;
                end
            end
            if (m_active) begin
                if (e_done) begin
                    m_active = 1'b0;
                    done_cyc = cyc;
                end else begin
                    m_rel++;
                end
            end else if (start) begin
                m_active  = 1'b1;
                m_rel     = 1;
                m_xfers   = 0;
                start_cyc = cyc;
                pc_cnt    = 0;
                busy_cnt  = 0;
                compute_expected();
            end
        end
        rnd = {$urandom, $urandom};
        if (pend) begin
            for (int l = 0; l < N; l++) begin
                a_rdata[l*DW +: DW] = ma[l][pend_addr];
                b_rdata[l*DW +: DW] = mb[pend_addr][l];
            end
        end else begin
            a_rdata = rnd[N*DW-1:0];
            b_rdata = ~rnd[N*DW-1:0];
        end
        pend      = op_en;
        pend_addr = int'(op_addr);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                acc[i*N+j] = pe_clear ? '0 :
                    acc[i*N+j] + qmul(row_data[i*DW +: DW], col_weight[j*DW +: DW]);
        for (int p = 0; p < N * N; p++) tmp[p*OW +: OW] = acc[p];
        for (int p = 4; p > 0; p--) pipe[p] = pipe[p-1];
        pipe[0]    = tmp;
        arr_result = pipe[4];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scaled_identity(input logic [DW-1:0] d);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? d : '0;
                mb[i][j] = DW'((i * N + j) * 'h40);
            end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 planned stalls at idx 5 and 15.
    task automatic run_job(input int rmode, input bit poke, input bit do_rst);
        int s5, s15, n;
        bit fin;
        s5 = 0; s15 = 0; n = 0; fin = 1'b0;
        start = 1'b1;
        wr_ready = 1'b1;
        tick();
        while (!fin) begin
            start = 1'b0;
            case (rmode)
                1: wr_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    wr_ready = 1'b1;
                    if (m_rel >= WB0 && m_xfers == 5 && s5 < 3) begin wr_ready = 1'b0; s5++; end
                    else if (m_rel >= WB0 && m_xfers == 15 && s15 < 1) begin wr_ready = 1'b0; s15++; end
                end
                default: wr_ready = 1'b1;
            endcase
            if (poke && m_active && (m_rel == 3 || (m_rel >= WB0 && m_xfers == N * N))) start = 1'b1;
            if (do_rst && m_active && m_rel >= WB0 && m_xfers == 7) begin
                rst = 1'b1;
                #1;
                chk("async_busy", busy, 0);     chk("async_wr_en", wr_en, 0);
                chk("async_wr_addr", wr_addr, 0); chk("async_wr_data", wr_data, 0);
                chk("async_op_en", op_en, 0);   chk("async_done", done, 0);
                tick();
                tick();
                rst = 1'b0;
                fin = 1'b1;
            end else if (!m_active && !start) begin
                fin = 1'b1;
            end else begin
                tick();
                n++;
                if (n > 300) begin
                    chk("job_timeout", n, 0);
                    fin = 1'b1;
                end
            end
        end
        wr_ready = 1'b1;
        tick();
    endtask

    initial begin
        set_scaled_identity(12'h040);
        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_wr_en", wr_en, 0);
        rst = 1'b0;
        tick();

        // Identity x B
        run_job(0, 1'b0, 1'b0);
        chk("id_latency", done_cyc - start_cyc, 28);
        chk("id_busy_cycles", busy_cnt, 28);
        chk("id_pe_clear_once", pc_cnt, 1);
        chk("id_pe_clear_cycle", pc_cyc - start_cyc, 1);
        chk("id_c11", got[5], 12'h140);
        chk("id_c33", got[15], 12'h3c0);

        // All ones
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin ma[i][j] = 12'h040; mb[i][j] = 12'h040; end
        run_job(0, 1'b0, 1'b0);
        chk("ones_c00", got[0], 12'h100);
        chk("ones_c32", got[14], 12'h100);
        chk("ones_pe_clear_once", pc_cnt, 1);

        // Back-to-back: identity then 2*I
        set_scaled_identity(12'h040);
        run_job(0, 1'b0, 1'b0);
        set_scaled_identity(12'h080);
        run_job(0, 1'b0, 1'b0);
        chk("b2b_c01", got[1], 12'h080);
        chk("b2b_c33", got[15], 12'h780);

        // Backpressure
        set_scaled_identity(12'h040);
        run_job(2, 1'b0, 1'b0);
        chk("bp_latency", done_cyc - start_cyc, 32);
        chk("bp_c07", got[7], 12'h1c0);

        // Start pulses during FETCH and DONE are ignored
        run_job(0, 1'b1, 1'b0);
        chk("poke_latency", done_cyc - start_cyc, 28);
        tick(); tick();
        chk("poke_idle", busy, 0);

        // Reset during writeback, then a clean job
        run_job(0, 1'b0, 1'b1);
        chk("rst_idle", busy, 0);
        run_job(0, 1'b0, 1'b0);
        chk("post_rst_latency", done_cyc - start_cyc, 28);
        chk("post_rst_c15", got[15], 12'h3c0);

        // Random operands with random backpressure
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = DW'($urandom_range(0, 4095));
                    mb[i][j] = DW'($urandom_range(0, 4095));
                end
            run_job(1, t[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mm_array_ctrl.md
Name: mm_array_ctrl

Overview:
- Sequencer for the N×N fixed-point matrix-multiply processing-element array (Q5.6, 12-bit).
- On `start`, it clears the array accumulators, streams the K=N operand slices from the A and B operand memories into the array rows and columns, and waits for the PE pipeline to drain.
- It then snapshots the N² accumulator outputs and writes them out row-major through a ready/enable result port.
- It sits between the operand/result memories and the PE array.

Parameters:
- `N`, 4, array dimension; matrices are N×N, inner dimension K=N.
- `DATA_WIDTH`, 12, operand width (signed Q5.6).
- `OUTPUT_WIDTH`, 12, PE accumulator/output width.
- `DRAIN_CYC`, 6, cycles from the last fetch address to the result snapshot.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: job request, sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse at job end.
- `op_addr` out clog2(N) (min 1): shared address to the A and B memories.
- `op_en` out 1: memory read enable.
- `a_rdata` in N*DATA_WIDTH: column k of A, lane i = A[i][k]. Valid 1 cycle after `op_en`.
- `b_rdata` in N*DATA_WIDTH: row k of B, lane j = B[k][j]. Valid 1 cycle after `op_en`.
- `row_data` out N*DATA_WIDTH: registered; lane i drives array row i.
- `col_weight` out N*DATA_WIDTH: registered; lane j drives array column j.
- `pe_clear` out 1: registered accumulator clear to the array, active-high.
- `arr_result` in N*N*OUTPUT_WIDTH: PE outputs; lane i*N+j = C[i][j].
- `wr_en` out 1: result write valid.
- `wr_ready` in 1: result sink ready.
- `wr_addr` out clog2(N*N): result index i*N+j.
- `wr_data` out OUTPUT_WIDTH: result value.

Behaviour:
- Reset: state=IDLE. All outputs 0, including `busy`, `done`, `op_en`, `pe_clear`, `wr_en`, `row_data`, `col_weight`, `wr_addr`, `wr_data`. Counters and snapshot cleared. Reset mid-job aborts immediately; there is no partial write-back after reset.
- States:
  - IDLE -> CLEAR when `start`=1.
  - CLEAR (1 cycle): `pe_clear`=1, then -> FETCH.
  - FETCH (N cycles): `op_en`=1, `op_addr`=k for k=0..N-1, then -> DRAIN.
  - DRAIN (DRAIN_CYC cycles) -> WRITEBACK.
  - WRITEBACK: N² results -> DONE.
  - DONE (1 cycle): `done`=1, then -> IDLE.
- `start` while not in IDLE is ignored; no queuing.
- Feed path: `row_data`/`col_weight` register `a_rdata`/`b_rdata` on the cycle after each `op_en`. They are therefore valid 2 cycles after address k is issued. In every other cycle they are 0, so the array accumulates zero products and holds its value.
- Array timing: the array forwards operands across rows and columns combinationally, so no skew is applied. All lanes update in the same cycle. A PE output reflects a fed operand pair 4 cycles after it appears on `row_data`/`col_weight`.
- Snapshot: with FETCH starting at cycle T, the last feed is at T+N+1 and final outputs are stable from T+N+5. At the clock edge ending the last DRAIN cycle (T+N+5), `arr_result` is copied into an internal snapshot. WRITEBACK uses only the snapshot.
- WRITEBACK handshake:
  - `wr_en`=1 with `wr_addr`/`wr_data` = snapshot[idx].
  - An item transfers on a cycle where `wr_en`&&`wr_ready`; idx then increments.
  - While `wr_ready`=0, `wr_en`, `wr_addr` and `wr_data` hold stable.
  - After the transfer of idx=N²-1, `wr_en` drops and the state goes to DONE.
- Arithmetic: the controller does no arithmetic on data; it only routes bits. Saturation and truncation belong to the PE. Lane order is LSB-first (lane 0 at bits [W-1:0]).
- Latency with `wr_ready` tied high, `start` at cycle 0 (counted in cycles):
  - CLEAR 1.
  - FETCH 2..N+1.
  - DRAIN N+2..N+1+DRAIN_CYC.
  - N² writes.
  - `done` next cycle; for N=4, `done` at cycle 28.
- `busy` is low in IDLE only. `done` and `start` in the same cycle: `start` is ignored, because DONE is not IDLE.

Test Plan:
- Identity × B, N=4: A=I (diag 0x040 = 1.0), B[k][j]=(k*4+j)*0x040, `wr_ready`=1. Required: 16 writes, `wr_addr` 0..15, `wr_data`=B row-major, `done` pulse at cycle 28, `busy` high cycles 1..28.
- All-ones: A=B=all 0x040. Required: every C=0x100 (4.0). `pe_clear` pulses exactly once, in cycle 1.
- Back-to-back jobs: run the identity job, then a second job with A=2·I (0x080). Required: second results = 2·B, with no residue from job 1, which proves the clear works.
- `wr_ready` backpressure: `wr_ready` low for 3 cycles at idx=5 and for 1 cycle at idx=15. Required: `wr_addr`/`wr_data` stable while stalled, no duplicate or skipped index, `done` delayed by 4 cycles.
- Start ignored: `start` pulsed during FETCH and during DONE. Required: no restart, and the result stream is identical to the single-job run.
- Reset mid-job: assert `rst` during WRITEBACK at idx=7. Required: all outputs 0 immediately, state IDLE. A new `start` then yields a full, correct 16-result job.
